// File: rtl/text_mode_pkg.sv
// Shared text-mode definitions: screen geometry, ASCII control codes and the
// writer state encoding. The VGA scan-out side imports the same constants.
package text_mode_pkg;

  localparam int COLUMNS     = 80;
  localparam int ROWS        = 30;
  localparam int CHAR_WIDTH  = 8;
  localparam int CHAR_HEIGHT = 16;
  localparam int ADDR_WIDTH  = 12;

  localparam logic [7:0] ASCII_BS      = 8'h08;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_FF      = 8'h0C;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] PRINTABLE_MIN = 8'h20;
  localparam logic [7:0] PRINTABLE_MAX = 8'h7E;

  localparam logic [6:0] BLANK_CHAR = 7'h20;

  typedef enum logic [1:0] {
    CLEAR_SCREEN,
    IDLE,
    CLEAR_LINE
  } writer_state_t;

  function automatic int unsigned cell_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINTABLE_MIN) && (c <= PRINTABLE_MAX);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor position register for the text console: advance with line wrap,
// newline with row wrap (no scroll), carriage return, backspace and home.
module text_cursor #(
  parameter int COLUMNS = text_mode_pkg::COLUMNS,
  parameter int ROWS    = text_mode_pkg::ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_advance,
  input  logic       i_newline,
  input  logic       i_carriage,
  input  logic       i_backspace,
  input  logic       i_home,
  output logic [6:0] o_x,
  output logic [4:0] o_y
);

  logic [6:0] r_x;
  logic [4:0] r_y;
  logic       w_last_col;
  logic [4:0] w_next_row;

  assign w_last_col = (r_x == 7'(COLUMNS - 1));
  assign w_next_row = (r_y == 5'(ROWS - 1)) ? '0 : r_y + 5'd1;

  always_ff @(posedge clk) begin
    if (rst || i_home) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_newline || (i_advance && w_last_col)) begin
      r_x <= '0;
      r_y <= w_next_row;
    end else if (i_carriage) begin
      r_x <= '0;
    end else if (i_backspace) begin
      if (r_x != '0) r_x <= r_x - 7'd1;
    end else if (i_advance) begin
      r_x <= r_x + 7'd1;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/text_console_writer.sv
// Writer side of the text-mode GRAM: turns an ASCII byte stream into 7-bit
// cell writes, handling cursor motion, control codes and row/screen clearing.
module text_console_writer #(
  parameter int         COLUMNS    = text_mode_pkg::COLUMNS,
  parameter int         ROWS       = text_mode_pkg::ROWS,
  parameter int         ADDR_WIDTH = text_mode_pkg::ADDR_WIDTH,
  parameter logic [6:0] BLANK_CHAR = text_mode_pkg::BLANK_CHAR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  output logic                  gram_write_enable,
  output logic [ADDR_WIDTH-1:0] gram_write_address,
  output logic [6:0]            gram_write_data,
  output logic [6:0]            cursor_x,
  output logic [4:0]            cursor_y,
  output logic                  busy
);

  import text_mode_pkg::*;

  localparam int CELLS = COLUMNS * ROWS;

  writer_state_t         r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [6:0]            r_data, w_data_nxt;

  logic                  w_accept;
  logic                  w_advance, w_newline, w_carriage, w_backspace, w_home;
  logic [6:0]            w_x;
  logic [4:0]            w_y;
  logic                  w_last_col;
  logic [ADDR_WIDTH-1:0] w_cursor_addr, w_bs_addr, w_line_addr;

  text_cursor #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_advance),
    .i_newline   (w_newline),
    .i_carriage  (w_carriage),
    .i_backspace (w_backspace),
    .i_home      (w_home),
    .o_x         (w_x),
    .o_y         (w_y)
  );

  assign w_accept   = char_valid && (r_state == IDLE);
  assign w_last_col = (w_x == 7'(COLUMNS - 1));

  // The cursor is frozen during CLEAR_LINE, so its row is the row being cleared.
  assign w_cursor_addr = ADDR_WIDTH'(cell_index(32'(w_y), 32'(w_x), COLUMNS));
  assign w_bs_addr     = ADDR_WIDTH'(cell_index(32'(w_y), 32'(w_x) - 32'd1, COLUMNS));
  assign w_line_addr   = ADDR_WIDTH'(cell_index(32'(w_y), 32'(r_clr_cnt), COLUMNS));

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_advance     = 1'b0;
    w_newline     = 1'b0;
    w_carriage    = 1'b0;
    w_backspace   = 1'b0;
    w_home        = 1'b0;

    case (r_state)
      CLEAR_SCREEN: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_clr_cnt;
        w_data_nxt = BLANK_CHAR;
        if (r_clr_cnt == ADDR_WIDTH'(CELLS - 1)) begin
          w_state_nxt   = IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end

      CLEAR_LINE: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = w_line_addr;
        w_data_nxt = BLANK_CHAR;
        if (r_clr_cnt == ADDR_WIDTH'(COLUMNS - 1)) begin
          w_state_nxt   = IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (w_accept) begin
          if (is_printable(char_data)) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_cursor_addr;
            w_data_nxt = char_data[6:0];
            // Last column: the character lands first, then the next row is blanked.
            if (w_last_col) begin
              w_newline     = 1'b1;
              w_state_nxt   = CLEAR_LINE;
              w_clr_cnt_nxt = '0;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            case (char_data)
              ASCII_LF: begin
                w_newline     = 1'b1;
                w_state_nxt   = CLEAR_LINE;
                w_clr_cnt_nxt = '0;
              end
              ASCII_CR: w_carriage = 1'b1;
              ASCII_BS: begin
                if (w_x != '0) begin
                  w_backspace = 1'b1;
                  w_we_nxt    = 1'b1;
                  w_addr_nxt  = w_bs_addr;
                  w_data_nxt  = BLANK_CHAR;
                end
              end
              ASCII_FF: begin
                w_home        = 1'b1;
                w_state_nxt   = CLEAR_SCREEN;
                w_clr_cnt_nxt = '0;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        w_state_nxt   = CLEAR_SCREEN;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_SCREEN;
      r_clr_cnt <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= BLANK_CHAR;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
    end
  end

  assign char_ready         = (r_state == IDLE);
  assign busy               = !char_ready;
  assign gram_write_enable  = r_we;
  assign gram_write_address = r_addr;
  assign gram_write_data    = r_data;
  assign cursor_x           = w_x;
  assign cursor_y           = w_y;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = '0;
  logic        char_ready;
  logic        gram_write_enable;
  logic [11:0] gram_write_address;
  logic [6:0]  gram_write_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  text_console_writer #(
    .COLUMNS    (80),
    .ROWS       (30),
    .ADDR_WIDTH (12),
    .BLANK_CHAR (7'h20)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .char_valid         (char_valid),
    .char_data          (char_data),
    .char_ready         (char_ready),
    .gram_write_enable  (gram_write_enable),
    .gram_write_address (gram_write_address),
    .gram_write_data    (gram_write_data),
    .cursor_x           (cursor_x),
    .cursor_y           (cursor_y),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_we"},    32'(gram_write_enable), 32'd0);
    check_eq({tag, "_addr"},  32'(gram_write_address), 32'd0);
    check_eq({tag, "_data"},  32'(gram_write_data), 32'h20);
    check_eq({tag, "_ready"}, 32'(char_ready), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd1);
    check_eq({tag, "_cx"},    32'(cursor_x), 32'd0);
    check_eq({tag, "_cy"},    32'(cursor_y), 32'd0);
  endtask

  task automatic expect_screen_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      if (gram_write_enable !== 1'b1 || gram_write_address !== 12'(i) ||
          gram_write_data !== 7'h20) bad++;
      if (i < 2399 && char_ready !== 1'b0) bad++;
    end
    check_eq({tag, "_writes"}, 32'(bad), 32'd0);
    check_eq({tag, "_ready"},  32'(char_ready), 32'd1);
    check_eq({tag, "_cx"},     32'(cursor_x), 32'd0);
    check_eq({tag, "_cy"},     32'(cursor_y), 32'd0);
  endtask

  task automatic expect_line_clear(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (gram_write_enable !== 1'b1 || gram_write_address !== 12'(base + i) ||
          gram_write_data !== 7'h20) bad++;
      if (i < 79 && char_ready !== 1'b0) bad++;
    end
    check_eq({tag, "_writes"}, 32'(bad), 32'd0);
    check_eq({tag, "_ready"},  32'(char_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check_eq("ready_timeout", 32'd1, 32'd0);
    tick();
    char_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int addr, input logic [6:0] data);
    check_eq({tag, "_we"},   32'(gram_write_enable), 32'd1);
    check_eq({tag, "_addr"}, 32'(gram_write_address), 32'(addr));
    check_eq({tag, "_data"}, 32'(gram_write_data), 32'(data));
  endtask

  task automatic expect_cursor(input string tag, input int x, input int y);
    check_eq({tag, "_cx"}, 32'(cursor_x), 32'(x));
    check_eq({tag, "_cy"}, 32'(cursor_y), 32'(y));
  endtask

  initial begin
    logic [7:0] c;

    // 1: reset then full-screen clear
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("rst");
    rst = 1'b0;
    expect_screen_clear("init");

    // 2: back-to-back printables at one char per cycle
    char_valid = 1'b1;
    char_data  = 8'h41;
    tick();
    expect_write("chA", 0, 7'h41);
    char_data = 8'h42;
    tick();
    expect_write("chB", 1, 7'h42);
    char_valid = 1'b0;
    expect_cursor("after_AB", 2, 0);

    // 3: fill row 0, wrap at the last column, row 1 cleared
    for (int col = 2; col < 80; col++) begin
      c = 8'h61 + 8'(col % 26);
      send_byte(c);
    end
    expect_write("col79", 79, 7'h62);
    expect_cursor("wrap_row1", 0, 1);
    check_eq("wrap_busy", 32'(busy), 32'd1);
    expect_line_clear("row1clr", 80);

    // 4: advance to row 29, LF wraps to row 0; CR returns without writing
    for (int k = 0; k < 28; k++) send_byte(8'h0A);
    for (int k = 0; k < 3; k++) send_byte(8'h78);
    expect_cursor("at_3_29", 3, 29);
    send_byte(8'h0A);
    check_eq("lf_nowrite", 32'(gram_write_enable), 32'd0);
    expect_cursor("lf_wrap", 0, 0);
    expect_line_clear("row0clr", 0);
    for (int k = 0; k < 10; k++) send_byte(8'h79);
    expect_cursor("at_10_0", 10, 0);
    send_byte(8'h0D);
    check_eq("cr_nowrite", 32'(gram_write_enable), 32'd0);
    expect_cursor("after_cr", 0, 0);

    // 5: backspace and ignored bytes on row 2
    send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h31);
    expect_write("row2_first", 160, 7'h31);
    for (int k = 0; k < 4; k++) send_byte(8'h32);
    expect_cursor("at_5_2", 5, 2);
    send_byte(8'h08);
    expect_write("bs", 164, 7'h20);
    expect_cursor("after_bs", 4, 2);
    send_byte(8'h0D);
    send_byte(8'h08);
    check_eq("bs_x0_nowrite", 32'(gram_write_enable), 32'd0);
    expect_cursor("bs_x0", 0, 2);
    send_byte(8'h07);
    check_eq("bel_nowrite", 32'(gram_write_enable), 32'd0);
    send_byte(8'hC1);
    check_eq("hi_nowrite", 32'(gram_write_enable), 32'd0);
    send_byte(8'h7F);
    check_eq("del_nowrite", 32'(gram_write_enable), 32'd0);
    expect_cursor("ignored", 0, 2);
    send_byte(8'h7E);
    expect_write("tilde", 160, 7'h7E);
    expect_cursor("after_tilde", 1, 2);

    // 6a: reset in the middle of a line clear
    send_byte(8'h0A);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("rst_mid");
    rst = 1'b0;
    expect_screen_clear("rst_mid_clr");

    // 6b: form feed mid-text
    send_byte(8'h5A);
    send_byte(8'h5A);
    expect_cursor("before_ff", 2, 0);
    send_byte(8'h0C);
    check_eq("ff_nowrite", 32'(gram_write_enable), 32'd0);
    check_eq("ff_ready",   32'(char_ready), 32'd0);
    expect_cursor("ff_home", 0, 0);
    expect_screen_clear("ff_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
